// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM states and arbitration owner ids for the SPI RAM controller.
package spi_ram_pkg;

  localparam logic [1:0] CMD_SET_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE     = 2'b01;
  localparam logic [1:0] CMD_SET_RADDR = 2'b10;
  localparam logic [1:0] CMD_READ      = 2'b11;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef enum logic {OWN_SPI, OWN_HOST} owner_t;

endpackage

// File: rtl/spi_ram_sp.sv
// Single-port synchronous RAM, read-first, one cycle read latency, no reset on contents.
module spi_ram_sp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= din;
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI command decoder sharing one RAM with a host port via round-robin arbitration.
// Optional burst addressing (address auto-increment) enabled by defining SPI_RAM_AUTO_INC_EN.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              spi_ovf
);

  localparam int CNT_W = $clog2(TX_HOLD + 1);

`ifdef SPI_RAM_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  state_t state, state_nxt;
  owner_t owner, owner_nxt, last_winner, last_winner_nxt;

  logic              rx_valid_q, capture, enqueue, accept;
  logic [1:0]        opcode;
  logic [7:0]        payload;
  logic [ADDR_W-1:0] wr_addr, rd_addr, wr_addr_nxt, rd_addr_nxt;
  logic              spi_pend, pend_we;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic              spi_grant, resp_spi, resp_host;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din, ram_dout;
  logic [DATA_W-1:0] tx_hold_q, host_rdata_q;
  logic [CNT_W-1:0]  tx_cnt;

  assign opcode  = rx_data[9:8];
  assign payload = rx_data[7:0];
  assign capture = rx_valid && !rx_valid_q;
  assign enqueue = capture && (opcode == CMD_WRITE || opcode == CMD_READ);
  // The single pending slot frees up in the same cycle its entry is granted.
  assign accept  = enqueue && (!spi_pend || spi_grant);

  spi_ram_sp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (ram_din),
    .dout (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_HOST;
      last_winner <= OWN_HOST;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_winner <= last_winner_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_winner_nxt = last_winner;
    ram_en          = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = pend_addr;
    ram_din         = pend_data;
    host_gnt        = 1'b0;
    spi_grant       = 1'b0;
    resp_spi        = 1'b0;
    resp_host       = 1'b0;
    case (state)
      IDLE: begin
        // last_winner only moves on a tie, so it tracks who won the last contested round.
        if (spi_pend && host_req) begin
          owner_nxt       = (last_winner == OWN_HOST) ? OWN_SPI : OWN_HOST;
          last_winner_nxt = owner_nxt;
          state_nxt       = ACCESS;
        end else if (spi_pend) begin
          owner_nxt = OWN_SPI;
          state_nxt = ACCESS;
        end else if (host_req) begin
          owner_nxt = OWN_HOST;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        ram_en = 1'b1;
        if (owner == OWN_HOST) begin
          ram_we   = host_we;
          ram_addr = host_addr;
          ram_din  = host_wdata;
          host_gnt = 1'b1;
        end else begin
          ram_we    = pend_we;
          spi_grant = 1'b1;
        end
        state_nxt = ram_we ? IDLE : RESP;
      end
      RESP: begin
        resp_spi  = (owner == OWN_SPI);
        resp_host = (owner == OWN_HOST);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_addr_nxt = wr_addr;
    rd_addr_nxt = rd_addr;
    if (capture && opcode == CMD_SET_WADDR) wr_addr_nxt = ADDR_W'(payload);
    if (capture && opcode == CMD_SET_RADDR) rd_addr_nxt = ADDR_W'(payload);
    if (AUTO_INC && accept && opcode == CMD_WRITE) wr_addr_nxt = wr_addr + ADDR_W'(1);
    if (AUTO_INC && accept && opcode == CMD_READ)  rd_addr_nxt = rd_addr + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_valid_q   <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      spi_pend     <= 1'b0;
      pend_we      <= 1'b0;
      pend_addr    <= '0;
      pend_data    <= '0;
      spi_ovf      <= 1'b0;
      tx_hold_q    <= '0;
      tx_cnt       <= '0;
      host_rdata_q <= '0;
    end else begin
      rx_valid_q <= rx_valid;
      wr_addr    <= wr_addr_nxt;
      rd_addr    <= rd_addr_nxt;
      if (accept) begin
        spi_pend  <= 1'b1;
        pend_we   <= (opcode == CMD_WRITE);
        pend_addr <= (opcode == CMD_WRITE) ? wr_addr : rd_addr;
        pend_data <= DATA_W'(payload);
      end else if (spi_grant) begin
        spi_pend <= 1'b0;
      end
      if (enqueue && !accept) spi_ovf <= 1'b1;
      if (resp_spi) begin
        tx_hold_q <= ram_dout;
        tx_cnt    <= CNT_W'(TX_HOLD - 1);
      end else if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - CNT_W'(1);
      end
      if (resp_host) host_rdata_q <= ram_dout;
    end
  end

  // RAM data is forwarded in the response cycle itself; the hold registers keep it afterwards.
  assign host_rvalid = resp_host;
  assign host_rdata  = resp_host ? ram_dout : host_rdata_q;
  assign tx_valid    = resp_spi || (tx_cnt != '0);
  assign tx_data     = resp_spi ? ram_dout : tx_hold_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed self-checking bench for spi_ram_ctrl; expectations follow SPI_RAM_AUTO_INC_EN when defined.
module tb_spi_ram_ctrl;

  localparam logic [1:0] OP_SWA = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RD  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt, host_rvalid;
  logic [7:0] host_rdata;
  logic       spi_ovf;

  int checks   = 0;
  int failures = 0;
  int hi;
  int ram_writes = 0;
  int w0;

  always #5 clk = ~clk;

  spi_ram_ctrl #(.ADDR_W(8), .DATA_W(8), .TX_HOLD(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .spi_ovf     (spi_ovf)
  );

  always @(negedge clk) begin
    if (rst_n && dut.ram_en && dut.ram_we) ram_writes++;
  end

  // Host must hold its request fields stable until it has seen host_gnt.
  logic       prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
  logic [7:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clk) begin
    if (rst_n && prev_req && !prev_gnt) begin
      assert (host_req && host_we === prev_we && host_addr === prev_addr && host_wdata === prev_wdata)
      else begin
        failures++;
        $error("[TB] FAIL host_protocol: req=%0b addr=0x%0h required stable addr=0x%0h", host_req, host_addr, prev_addr);
      end
    end
    prev_req   = host_req;
    prev_gnt   = host_gnt;
    prev_we    = host_we;
    prev_addr  = host_addr;
    prev_wdata = host_wdata;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One SPI word with a single-cycle rx_valid pulse; returns two cycles after capture.
  task automatic applyStimulus(input logic [1:0] op, input logic [7:0] payload);
    rx_data  = {op, payload};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
  endtask

  task automatic hostWrite(input logic [7:0] addr, input logic [7:0] data, input string tag);
    int n = 0;
    host_req = 1'b1; host_we = 1'b1; host_addr = addr; host_wdata = data;
    do begin tick(); n++; end while (!host_gnt && n < 10);
    checkOutput({tag, "_gnt"}, 32'(host_gnt), 32'd1);
    tick();
    host_req = 1'b0;
  endtask

  task automatic hostRead(input logic [7:0] addr, input logic [7:0] expected, input string tag);
    int n = 0;
    host_req = 1'b1; host_we = 1'b0; host_addr = addr;
    do begin tick(); n++; end while (!host_gnt && n < 10);
    checkOutput({tag, "_gnt"}, 32'(host_gnt), 32'd1);
    tick();
    host_req = 1'b0;
    checkOutput({tag, "_rvalid"}, 32'(host_rvalid), 32'd1);
    checkOutput(tag, 32'(host_rdata), 32'(expected));
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) tick();
    checkOutput("rst_tx_data", 32'(tx_data), 32'h0);
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("rst_host_gnt", 32'(host_gnt), 32'h0);
    checkOutput("rst_host_rvalid", 32'(host_rvalid), 32'h0);
    checkOutput("rst_host_rdata", 32'(host_rdata), 32'h0);
    checkOutput("rst_spi_ovf", 32'(spi_ovf), 32'h0);
    rst_n = 1'b1;

    // SPI write then read back: tx_valid starts 3 cycles after READ capture, lasts 8 cycles
    applyStimulus(OP_SWA, 8'h12);
    applyStimulus(OP_WR, 8'hA5);
    applyStimulus(OP_SRA, 8'h12);
    applyStimulus(OP_RD, 8'h00);
    checkOutput("spi_rd_not_early", 32'(tx_valid), 32'h0);
    tick();
    checkOutput("spi_rd_valid", 32'(tx_valid), 32'h1);
    checkOutput("spi_rd_data", 32'(tx_data), 32'hA5);
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!tx_valid) break;
      hi++;
    end
    checkOutput("spi_tx_hold_len", 32'(hi), 32'd8);
    checkOutput("spi_tx_data_held", 32'(tx_data), 32'hA5);

    // rx_valid held high for 20 cycles yields a single command
    applyStimulus(OP_SWA, 8'h20);
    w0 = ram_writes;
    rx_data = {OP_WR, 8'h33};
    rx_valid = 1'b1;
    repeat (20) tick();
    rx_valid = 1'b0;
    repeat (5) tick();
    checkOutput("level_one_write", 32'(ram_writes - w0), 32'd1);
    checkOutput("level_no_ovf", 32'(spi_ovf), 32'h0);

    // Host write then read with exact cycle timing
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h7E;
    tick();
    checkOutput("hw_gnt", 32'(host_gnt), 32'h1);
    tick();
    checkOutput("hw_gnt_pulse", 32'(host_gnt), 32'h0);
    checkOutput("hw_no_rvalid", 32'(host_rvalid), 32'h0);
    host_we = 1'b0;
    tick();
    checkOutput("hr_gnt", 32'(host_gnt), 32'h1);
    checkOutput("hr_rvalid_early", 32'(host_rvalid), 32'h0);
    checkOutput("hr_rdata_before", 32'(host_rdata), 32'h0);
    tick();
    host_req = 1'b0;
    checkOutput("hr_rvalid", 32'(host_rvalid), 32'h1);
    checkOutput("hr_rdata", 32'(host_rdata), 32'h7E);
    tick();
    checkOutput("hr_rvalid_pulse", 32'(host_rvalid), 32'h0);
    checkOutput("hr_rdata_held", 32'(host_rdata), 32'h7E);
    hostWrite(8'h00, 8'h5A, "hw0");

    // Tie right after reset: SPI first, host next; the next tie goes to the host
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rx_data = {OP_RD, 8'h00};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    tick();
    checkOutput("tie1_host_waits", 32'(host_gnt), 32'h0);
    tick();
    checkOutput("tie1_spi_valid", 32'(tx_valid), 32'h1);
    checkOutput("tie1_spi_data", 32'(tx_data), 32'h5A);
    tick();
    tick();
    checkOutput("tie1_host_gnt", 32'(host_gnt), 32'h1);
    tick();
    host_req = 1'b0;
    checkOutput("tie1_host_rdata", 32'(host_rdata), 32'h7E);
    tick();
    applyStimulus(OP_SRA, 8'h00);
    rx_data = {OP_RD, 8'h00};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    tick();
    checkOutput("tie2_host_gnt", 32'(host_gnt), 32'h1);
    tick();
    host_req = 1'b0;
    checkOutput("tie2_host_rvalid", 32'(host_rvalid), 32'h1);
    tick();
    tick();
    checkOutput("tie2_spi_not_yet", 32'(tx_valid), 32'h0);
    tick();
    checkOutput("tie2_spi_valid", 32'(tx_valid), 32'h1);
    tick();

    // Second WRITE captured while the first is still queued behind a host access
    applyStimulus(OP_SWA, 8'h50);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    rx_data = {OP_WR, 8'h11};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checkOutput("ovf_host_gnt", 32'(host_gnt), 32'h1);
    tick();
    host_req = 1'b0;
    checkOutput("ovf_host_rdata", 32'(host_rdata), 32'h33);
    checkOutput("ovf_before", 32'(spi_ovf), 32'h0);
    rx_data = {OP_WR, 8'h22};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    checkOutput("ovf_set", 32'(spi_ovf), 32'h1);
    repeat (6) tick();
    checkOutput("ovf_sticky", 32'(spi_ovf), 32'h1);
    hostRead(8'h50, 8'h11, "ovf_first_kept");
    tick();

    // Back-to-back writes across the 0xFF boundary
    applyStimulus(OP_SWA, 8'hFF);
    applyStimulus(OP_WR, 8'h01);
    applyStimulus(OP_WR, 8'h02);
    repeat (4) tick();
`ifdef SPI_RAM_AUTO_INC_EN
    hostRead(8'hFF, 8'h01, "burst_ff");
    hostRead(8'h00, 8'h02, "burst_00");
`else
    hostRead(8'hFF, 8'h02, "burst_ff");
    hostRead(8'h00, 8'h5A, "burst_00");
`endif
    tick();

    // Reset asserted during a host ACCESS
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    tick();
    checkOutput("midrst_gnt", 32'(host_gnt), 32'h1);
    rst_n = 1'b0;
    tick();
    host_req = 1'b0;
    checkOutput("midrst_tx_data", 32'(tx_data), 32'h0);
    checkOutput("midrst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("midrst_host_gnt", 32'(host_gnt), 32'h0);
    checkOutput("midrst_host_rvalid", 32'(host_rvalid), 32'h0);
    checkOutput("midrst_host_rdata", 32'(host_rdata), 32'h0);
    checkOutput("midrst_spi_ovf", 32'(spi_ovf), 32'h0);
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_abandoned", 32'(host_rvalid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
